// File: rtl/priority_encoder_pkg.sv
// Shared types and default widths for the registered priority encoder.
// Imported by the interface, the selector and the top level.
package priority_encoder_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int ENCODE_WIDTH = 3;

endpackage

// File: rtl/priority_encoder_fsm_if.sv
// Request/handshake bundle between event sources, the encoder and its consumer.
// The master side drives requests and ack; the slave side is the encoder.
interface priority_encoder_fsm_if
    import priority_encoder_pkg::*;
#(
    parameter int encodeWidth = ENCODE_WIDTH,
    parameter int decodeWidth = 2 ** encodeWidth
) ();

    logic [decodeWidth-1:0] req;
    logic                   ack;
    logic [encodeWidth-1:0] code;
    logic                   valid;
    logic [decodeWidth-1:0] pending;
    logic                   overrun;

    modport master (
        output req,
        output ack,
        input  code,
        input  valid,
        input  pending,
        input  overrun
    );

    modport slave (
        input  req,
        input  ack,
        output code,
        output valid,
        output pending,
        output overrun
    );

endinterface

// File: rtl/priority_select.sv
// Combinational highest-set-bit finder.
// Bit decodeWidth-1 has top priority; any flags a non-zero input.
module priority_select
    import priority_encoder_pkg::*;
#(
    parameter int encodeWidth = ENCODE_WIDTH,
    parameter int decodeWidth = 2 ** encodeWidth
) (
    input  logic [decodeWidth-1:0] bits,
    output logic [encodeWidth-1:0] index,
    output logic                   any
);

    // Scan upward so the last (highest) set bit wins.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < decodeWidth; i++) begin
            if (bits[i]) begin
                index = encodeWidth'(i);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_fsm.sv
// Registered priority encoder: sticky pending bits, highest index presented
// with a valid/ack handshake, plus a sticky overrun flag.
module priority_encoder_fsm
    import priority_encoder_pkg::*;
#(
    parameter int encodeWidth = ENCODE_WIDTH,
    parameter int decodeWidth = 2 ** encodeWidth
) (
    input  logic clk,
    input  logic rst_n,
    priority_encoder_fsm_if.slave bus
);

    state_t                 state;
    state_t                 state_next;
    logic [decodeWidth-1:0] pending;
    logic [decodeWidth-1:0] pending_next;
    logic [decodeWidth-1:0] clr;
    logic [decodeWidth-1:0] one_hot;
    logic [encodeWidth-1:0] code;
    logic [encodeWidth-1:0] code_next;
    logic [encodeWidth-1:0] sel_index;
    logic                   sel_any;
    logic                   valid;
    logic                   valid_next;
    logic                   overrun;
    logic                   overrun_next;
    logic                   take;

    // Selection looks only at registered pending, never at raw req.
    priority_select #(
        .encodeWidth (encodeWidth),
        .decodeWidth (decodeWidth)
    ) u_select (
        .bits  (pending),
        .index (sel_index),
        .any   (sel_any)
    );

    assign take    = (state == PRESENT) && bus.ack;
    assign one_hot = decodeWidth'(1) << code;
    assign clr     = take ? one_hot : '0;

    // Pending bits: clear the served bit, new requests set (set wins).
    always_comb begin
        pending_next = (pending & ~clr) | bus.req;
        overrun_next = overrun | (|(bus.req & pending & ~clr));
    end

    // Next-state and presented code/valid.
    always_comb begin
        state_next = state;
        code_next  = code;
        valid_next = valid;
        unique case (state)
            IDLE: begin
                if (sel_any) begin
                    code_next  = sel_index;
                    valid_next = 1'b1;
                    state_next = PRESENT;
                end else begin
                    valid_next = 1'b0;
                end
            end
            PRESENT: begin
                if (bus.ack) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // State, pending and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            code    <= code_next;
            valid   <= valid_next;
            overrun <= overrun_next;
        end
    end

    assign bus.code    = code;
    assign bus.valid   = valid;
    assign bus.pending = pending;
    assign bus.overrun = overrun;

endmodule

// File: tb/tb_priority_encoder_fsm.sv
// Self-checking bench for priority_encoder_fsm with a behavioural model.
// Directed scenarios plus randomized traffic and an exhaustive selector sweep.
module tb_priority_encoder_fsm;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Behavioural model of the observable state.
    bit       m_valid;
    int       m_code;
    bit [7:0] m_pend;
    bit       m_ovr;

    logic [7:0] sel_bits;
    logic [2:0] sel_index;
    logic       sel_any;

    priority_encoder_fsm_if #(.encodeWidth(3)) bus ();

    priority_encoder_fsm #(.encodeWidth(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    priority_select #(.encodeWidth(3)) u_sel (
        .bits  (sel_bits),
        .index (sel_index),
        .any   (sel_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int highest(bit [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 0;
        m_code  = 0;
        m_pend  = '0;
        m_ovr   = 0;
    endfunction

    // One clock edge of the spec's rules, using pre-edge model state.
    function automatic void model_step(bit [7:0] r, bit a);
        bit       served;
        bit [7:0] next_pend;
        int       h;
        served = m_valid && a;
        for (int i = 0; i < 8; i++) begin
            bit cleared;
            cleared = served && (i == m_code);
            if (r[i] && m_pend[i] && !cleared) m_ovr = 1;
            next_pend[i] = (m_pend[i] && !cleared) || r[i];
        end
        if (!m_valid) begin
            h = highest(m_pend);
            if (h >= 0) begin
                m_valid = 1;
                m_code  = h;
            end
        end else if (a) begin
            m_valid = 0;
        end
        m_pend = next_pend;
    endfunction

    function automatic logic [12:0] model_vec();
        return {m_valid, 3'(m_code), m_pend, m_ovr};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.valid, bus.code, bus.pending, bus.overrun};
    endfunction

    // Drive at the falling edge, clock once, return at the next falling edge.
    task automatic cycle(input logic [7:0] r, input logic a);
        bus.req = r;
        bus.ack = a;
        @(posedge clk);
        model_step(r, a);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        bus.ack = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (dut_vec() !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", dut_vec());
        end
        cycle(8'b1010_0000, 1'b0);
        cycle(8'h00, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd7 ||
            bus.pending !== 8'b1010_0000) begin
            errors++;
            $display("FAIL reset_setup: got v=%b c=%0d p=%b want v=1 c=7 p=10100000",
                     bus.valid, bus.code, bus.pending);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 13'd0) begin
            errors++;
            $display("FAIL reset_async: got %h want 0", dut_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b0);
            checks++;
            if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
                errors++;
                $display("FAIL reset_release: got v=%b p=%b want v=0 p=0",
                         bus.valid, bus.pending);
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        cycle(8'b0000_0010, 1'b0);
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'b0000_0010) begin
            errors++;
            $display("FAIL single_latch: got v=%b p=%b want v=0 p=00000010",
                     bus.valid, bus.pending);
        end
        cycle(8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.code !== 3'd1) begin
                errors++;
                $display("FAIL single_hold[%0d]: got v=%b c=%0d want v=1 c=1",
                         i, bus.valid, bus.code);
            end
            cycle(8'h00, 1'b0);
        end
        cycle(8'h00, 1'b1);
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL single_ack: got v=%b p=%b want v=0 p=0",
                     bus.valid, bus.pending);
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_seq [7];
        apply_reset();
        exp_seq[0] = 4'b0_000;
        exp_seq[1] = 4'b1_111;
        exp_seq[2] = 4'b0_111;
        exp_seq[3] = 4'b1_010;
        exp_seq[4] = 4'b0_010;
        exp_seq[5] = 4'b1_000;
        exp_seq[6] = 4'b0_000;
        for (int i = 0; i < 7; i++) begin
            cycle(i == 0 ? 8'b1000_0101 : 8'h00, 1'b1);
            checks++;
            if ({bus.valid, bus.code} !== exp_seq[i] ||
                dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL priority_seq[%0d]: got v=%b c=%0d want v=%b c=%0d",
                         i, bus.valid, bus.code, exp_seq[i][3], exp_seq[i][2:0]);
            end
        end
        checks++;
        if (bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL priority_final: got p=%b want 0", bus.pending);
        end
    endtask

    task automatic test_no_preempt();
        apply_reset();
        cycle(8'b0000_0100, 1'b0);
        cycle(8'h00, 1'b0);
        cycle(8'b1000_0000, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd2 ||
            bus.pending !== 8'b1000_0100) begin
            errors++;
            $display("FAIL no_preempt_hold: got v=%b c=%0d p=%b want v=1 c=2 p=10000100",
                     bus.valid, bus.code, bus.pending);
        end
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd7) begin
            errors++;
            $display("FAIL no_preempt_next: got v=%b c=%0d want v=1 c=7",
                     bus.valid, bus.code);
        end
        cycle(8'h00, 1'b1);
    endtask

    task automatic test_set_wins();
        apply_reset();
        cycle(8'b0001_0000, 1'b0);
        cycle(8'h00, 1'b0);
        cycle(8'b0001_0000, 1'b1);
        checks++;
        if (bus.valid !== 1'b0 || bus.pending !== 8'b0001_0000 ||
            bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_ack: got v=%b p=%b o=%b want v=0 p=00010000 o=0",
                     bus.valid, bus.pending, bus.overrun);
        end
        cycle(8'h00, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd4) begin
            errors++;
            $display("FAIL set_wins_repr: got v=%b c=%0d want v=1 c=4",
                     bus.valid, bus.code);
        end
        cycle(8'b0010_0000, 1'b0);
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early: got %b want 0", bus.overrun);
        end
        cycle(8'b0010_0000, 1'b0);
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b want 1", bus.overrun);
        end
        for (int i = 0; i < 4; i++) cycle(8'h00, 1'b1);
        checks++;
        if (bus.overrun !== 1'b1 || bus.pending !== 8'h00) begin
            errors++;
            $display("FAIL overrun_sticky: got o=%b p=%b want o=1 p=0",
                     bus.overrun, bus.pending);
        end
    endtask

    task automatic test_ack_idle();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b1);
            checks++;
            if (dut_vec() !== 13'd0) begin
                errors++;
                $display("FAIL ack_idle[%0d]: got %h want 0", i, dut_vec());
            end
        end
    endtask

    task automatic test_all_set();
        apply_reset();
        cycle(8'hFF, 1'b0);
        cycle(8'h00, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd7) begin
            errors++;
            $display("FAIL all_set: got v=%b c=%0d want v=1 c=7",
                     bus.valid, bus.code);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       a;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            a = 1'($urandom_range(0, 1));
            cycle(r, a);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_select();
        int h;
        for (int v = 0; v < 256; v++) begin
            sel_bits = 8'(v);
            #1;
            h = highest(8'(v));
            checks++;
            if (sel_any !== (h >= 0) || (h >= 0 && sel_index !== 3'(h))) begin
                errors++;
                $display("FAIL select[%0d]: got any=%b idx=%0d want any=%b idx=%0d",
                         v, sel_any, sel_index, h >= 0, h);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.ack  = 1'b0;
        sel_bits = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_set_wins();
        test_ack_idle();
        test_all_set();
        test_random();
        test_select();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
